// File: rtl/erosion_dilation_top_pkg.sv
// Shared constants and types for the frame-difference motion-mask pipeline.
// Holds the luma coefficients, the default frame geometry, the per-block
// pipeline depths (which together give the fixed input-to-output latency),
// the morphology mode type and a small absolute-difference helper.
package erosion_dilation_top_pkg;

   // Y = (77*R + 150*G + 29*B) >> 8; the weights sum to 256.
   localparam logic [7:0] COEF_R = 8'd77;
   localparam logic [7:0] COEF_G = 8'd150;
   localparam logic [7:0] COEF_B = 8'd29;

   localparam int DEF_IMG_HDISP   = 640;
   localparam int DEF_IMG_VDISP   = 480;
   localparam int DEF_DIFF_THRESH = 20;

   localparam int LUMA_STAGES   = 2;
   localparam int DIFF_STAGES   = 1;
   localparam int MORPH_STAGES  = 2;
   localparam int ERODE_TAP     = LUMA_STAGES + DIFF_STAGES;
   localparam int DILATE_TAP    = ERODE_TAP + MORPH_STAGES;
   localparam int TOTAL_LATENCY = DILATE_TAP + MORPH_STAGES;  // 7

   typedef enum logic {
      MORPH_ERODE  = 1'b0,
      MORPH_DILATE = 1'b1
   } morph_mode_t;

   function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/erosion_dilation_top_morph3x3.sv
// 3x3 binary morphology (erosion or dilation) on a raster stream.
// Ports:
//   clk, srst       clock and synchronous active-high reset
//   vsync, href     frame/line sync aligned with mask
//   clken           pixel qualifier; a pixel is taken when href & clken
//   mask            binary input pixel
//   result          AND (erode) or OR (dilate) of the 3x3 neighbourhood
//                   centred one column left and one row up of the current
//                   input pixel; two cycles after that pixel.
// Taps that fall left of column 0 or above row 0 read as 0.
module erosion_dilation_top_morph3x3
   import erosion_dilation_top_pkg::*;
#(
   parameter morph_mode_t MODE      = MORPH_ERODE,
   parameter int          IMG_HDISP = DEF_IMG_HDISP,
   parameter int          IMG_VDISP = DEF_IMG_VDISP
) (
   input  logic clk,
   input  logic srst,
   input  logic vsync,
   input  logic href,
   input  logic clken,
   input  logic mask,
   output logic result
);

   localparam int AW = (IMG_HDISP > 2) ? $clog2(IMG_HDISP) : 2;
   localparam int RW = $clog2(IMG_VDISP + 1) + 1;

   // One 2-bit word per column: [1] = row y-1, [0] = row y-2.
   logic [1:0]    line_mem [IMG_HDISP];

   logic          accept;
   logic [AW-1:0] col_cnt_reg;
   logic [RW-1:0] row_cnt_reg;
   logic          href_reg;
   logic [1:0]    rd_reg;        // registered line-buffer read
   logic          cur_reg;       // current-row bit of the newest column
   logic [1:0]    row_ok_reg;    // [1]: row >= 2, [0]: row >= 1
   logic [1:0]    col_ok_reg;    // [1]: col >= 2, [0]: col >= 1
   logic [2:0]    win1_reg;      // column x-1, {y-2, y-1, y}
   logic [2:0]    win2_reg;      // column x-2
   logic          wr_pend_reg;
   logic [AW-1:0] wr_addr_reg;
   logic [2:0]    col0;
   logic [8:0]    taps;

   assign accept = href & clken;

   // Newest column; rows above the frame are forced to 0 here so that the
   // older window columns inherit the masking as they shift.
   assign col0 = {rd_reg[0] & row_ok_reg[1], rd_reg[1] & row_ok_reg[0], cur_reg};
   assign taps = {win2_reg & {3{col_ok_reg[1]}}, win1_reg & {3{col_ok_reg[0]}}, col0};

   // Line buffer: the read of column x is registered, and the updated word
   // {row y, row y-1} is written back one cycle later once the old row y-1
   // bit is out of the read register. The next accepted column is always a
   // different address, so the write never collides with a read.
   always_ff @(posedge clk) begin
      if (wr_pend_reg)
         line_mem[wr_addr_reg] <= {cur_reg, rd_reg[1]};
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         col_cnt_reg <= '0;
         row_cnt_reg <= '0;
         href_reg    <= 1'b0;
         rd_reg      <= '0;
         cur_reg     <= 1'b0;
         row_ok_reg  <= '0;
         col_ok_reg  <= '0;
         win1_reg    <= '0;
         win2_reg    <= '0;
         wr_pend_reg <= 1'b0;
         wr_addr_reg <= '0;
         result      <= 1'b0;
      end else begin
         href_reg    <= href;
         wr_pend_reg <= accept;

         if (!href)
            col_cnt_reg <= '0;
         else if (accept)
            col_cnt_reg <= col_cnt_reg + AW'(1);

         // Row count restarts in the vertical sync line and steps at each
         // end of line; it saturates instead of wrapping.
         if (!vsync)
            row_cnt_reg <= '0;
         else if (href_reg && !href && (row_cnt_reg != '1))
            row_cnt_reg <= row_cnt_reg + RW'(1);

         if (accept) begin
            rd_reg      <= line_mem[col_cnt_reg];
            cur_reg     <= mask;
            wr_addr_reg <= col_cnt_reg;
            row_ok_reg  <= {row_cnt_reg >= RW'(2), row_cnt_reg >= RW'(1)};
            col_ok_reg  <= {col_cnt_reg >= AW'(2), col_cnt_reg >= AW'(1)};
            win1_reg    <= col0;
            win2_reg    <= win1_reg;
         end

         result <= (MODE == MORPH_ERODE) ? (&taps) : (|taps);
      end
   end

endmodule

// File: rtl/erosion_dilation_top.sv
// Frame-difference motion mask: two RGB888 streams -> luma -> thresholded
// absolute difference -> 3x3 erosion -> 3x3 dilation.
// Ports:
//   sys_clk, sys_rst                 clock, synchronous active-high reset
//   per_frame_vsync/href/clken       input timing (clken qualifies pixels)
//   pix_data_in_A, pix_data_in_B     current / reference pixel, {R,G,B}
//   post_frame_vsync/href/clken      input timing delayed by 7 cycles
//   post_img_Bit                     opened motion mask, aligned with post_*
// The mask image leaves shifted 2 px right and 2 px down.
module erosion_dilation_top
   import erosion_dilation_top_pkg::*;
#(
   parameter int IMG_HDISP   = DEF_IMG_HDISP,
   parameter int IMG_VDISP   = DEF_IMG_VDISP,
   parameter int DIFF_THRESH = DEF_DIFF_THRESH
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   input  logic [23:0] pix_data_in_A,
   input  logic [23:0] pix_data_in_B,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_clken,
   output logic        post_img_Bit
);

   localparam logic [7:0] THRESH = 8'(DIFF_THRESH);

   logic [23:0] pix  [2];
   logic [7:0]  luma [2];
   logic        bin_reg;
   logic        erode_bit;
   logic [2:0]  sync_in;
   logic [2:0]  sync_pipe [1:TOTAL_LATENCY];   // {vsync, href, clken}

   assign pix[0] = pix_data_in_A;
   assign pix[1] = pix_data_in_B;

   // Luma per stream: products in stage 1, sum and scale in stage 2.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_luma
         logic [15:0] prod_r_reg, prod_g_reg, prod_b_reg;
         logic [17:0] sum;
         logic [7:0]  luma_reg;

         assign sum = 18'(prod_r_reg) + 18'(prod_g_reg) + 18'(prod_b_reg);

         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               prod_r_reg <= '0;
               prod_g_reg <= '0;
               prod_b_reg <= '0;
               luma_reg   <= '0;
            end else begin
               prod_r_reg <= 16'(COEF_R) * 16'(pix[gi][23:16]);
               prod_g_reg <= 16'(COEF_G) * 16'(pix[gi][15:8]);
               prod_b_reg <= 16'(COEF_B) * 16'(pix[gi][7:0]);
               luma_reg   <= 8'(sum >> 8);
            end
         end

         assign luma[gi] = luma_reg;
      end
   endgenerate

   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         bin_reg <= 1'b0;
      else
         bin_reg <= (abs_diff8(luma[0], luma[1]) > THRESH);
   end

   // Timing delay line; intermediate taps feed each morph stage the sync
   // that lines up with its own input bit.
   assign sync_in = {per_frame_vsync, per_frame_href, per_frame_clken};

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int k = 1; k <= TOTAL_LATENCY; k++)
            sync_pipe[k] <= '0;
      end else begin
         sync_pipe[1] <= sync_in;
         for (int k = 2; k <= TOTAL_LATENCY; k++)
            sync_pipe[k] <= sync_pipe[k-1];
      end
   end

   erosion_dilation_top_morph3x3 #(
      .MODE      (MORPH_ERODE),
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP)
   ) u_erode (
      .clk    (sys_clk),
      .srst   (sys_rst),
      .vsync  (sync_pipe[ERODE_TAP][2]),
      .href   (sync_pipe[ERODE_TAP][1]),
      .clken  (sync_pipe[ERODE_TAP][0]),
      .mask   (bin_reg),
      .result (erode_bit)
   );

   erosion_dilation_top_morph3x3 #(
      .MODE      (MORPH_DILATE),
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP)
   ) u_dilate (
      .clk    (sys_clk),
      .srst   (sys_rst),
      .vsync  (sync_pipe[DILATE_TAP][2]),
      .href   (sync_pipe[DILATE_TAP][1]),
      .clken  (sync_pipe[DILATE_TAP][0]),
      .mask   (erode_bit),
      .result (post_img_Bit)
   );

   assign post_frame_vsync = sync_pipe[TOTAL_LATENCY][2];
   assign post_frame_href  = sync_pipe[TOTAL_LATENCY][1];
   assign post_frame_clken = sync_pipe[TOTAL_LATENCY][0];

endmodule

// File: tb/tb_erosion_dilation_top.sv
// Bench for erosion_dilation_top on a reduced 24x16 frame. Expected masks are
// computed from the images: luma -> |dY| > 20 -> 3x3 AND with out-of-frame
// taps as 0 -> 3x3 OR over the eroded image, giving the 2px-shifted result.
module tb_erosion_dilation_top;

   localparam int W   = 24;
   localparam int H   = 16;
   localparam int THR = 20;
   localparam int LAT = 7;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        per_frame_vsync, per_frame_href, per_frame_clken;
   logic [23:0] pix_data_in_A, pix_data_in_B;
   logic        post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;

   always #5 sys_clk = ~sys_clk;

   erosion_dilation_top #(
      .IMG_HDISP   (W),
      .IMG_VDISP   (H),
      .DIFF_THRESH (THR)
   ) dut (
      .sys_clk          (sys_clk),
      .sys_rst          (sys_rst),
      .per_frame_vsync  (per_frame_vsync),
      .per_frame_href   (per_frame_href),
      .per_frame_clken  (per_frame_clken),
      .pix_data_in_A    (pix_data_in_A),
      .pix_data_in_B    (pix_data_in_B),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .post_img_Bit     (post_img_Bit)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [23:0] img_a [H][W];
   logic [23:0] img_b [H][W];
   logic        exp_mask [H][W];
   logic        got_q [$];
   int          lines_seen = 0;
   int          line_px = 0;
   int          rst_age = 0;
   bit          check_lines = 1'b1;
   logic [2:0]  hist [8];
   logic        href_prev = 1'b0;

   task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic int luma_of(input logic [23:0] p);
      return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
   endfunction

   task automatic compute_expected();
      int m [H][W];
      int e [H][W];
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            int d;
            d = luma_of(img_a[y][x]) - luma_of(img_b[y][x]);
            if (d < 0) d = -d;
            m[y][x] = (d > THR) ? 1 : 0;
         end
      // erosion: any tap outside the frame is 0, so the AND is 0 there
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            e[y][x] = (x >= 2 && y >= 2) ? 1 : 0;
            if (e[y][x] == 1)
               for (int dy = 0; dy < 3; dy++)
                  for (int dx = 0; dx < 3; dx++)
                     if (m[y-dy][x-dx] == 0) e[y][x] = 0;
         end
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            exp_mask[y][x] = 1'b0;
            for (int dy = 0; dy < 3; dy++)
               for (int dx = 0; dx < 3; dx++)
                  if (y - dy >= 0 && x - dx >= 0 && e[y-dy][x-dx] == 1)
                     exp_mask[y][x] = 1'b1;
         end
   endtask

   task automatic fill(input logic [23:0] a, input logic [23:0] b);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            img_a[y][x] = a;
            img_b[y][x] = b;
         end
   endtask

   task automatic rect_b(input int x0, input int y0, input int w, input int h, input logic [23:0] c);
      for (int y = y0; y < y0 + h && y < H; y++)
         for (int x = x0; x < x0 + w && x < W; x++)
            img_b[y][x] = c;
   endtask

   // mode 0: clken always high, 1: random stalls, 2: clken toggles every cycle
   task automatic drive_frame(input int mode, input int rst_line);
      int phase = 0;
      bit rst_done = 1'b0;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      repeat (6) step();
      per_frame_vsync = 1'b1;
      repeat (4) step();
      for (int y = 0; y < H; y++) begin
         int x = 0;
         per_frame_href = 1'b1;
         while (x < W) begin
            bit en;
            if (y == rst_line && x == W / 2 && !rst_done) begin
               rst_done = 1'b1;
               sys_rst = 1'b1;
               @(posedge sys_clk);
               @(negedge sys_clk);
               check_result("rst_outputs",
                  {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit}, 4'h0);
               @(posedge sys_clk);
               @(posedge sys_clk);
               #1;
               sys_rst = 1'b0;
            end
            case (mode)
               0:       en = 1'b1;
               1:       en = ($urandom_range(0, 2) != 0);
               default: en = ((phase % 2) == 0);
            endcase
            phase++;
            per_frame_clken = en;
            if (en) begin
               pix_data_in_A = img_a[y][x];
               pix_data_in_B = img_b[y][x];
               x++;
            end else begin
               pix_data_in_A = 24'($urandom);
               pix_data_in_B = 24'($urandom);
            end
            step();
         end
         per_frame_href  = 1'b0;
         per_frame_clken = 1'b0;
         repeat (4) step();
      end
      repeat (12) step();
   endtask

   task automatic run_frame(input string name, input int mode);
      int ones = 0;
      compute_expected();
      got_q.delete();
      lines_seen = 0;
      drive_frame(mode, -1);
      check_result({name, "_pixels"}, got_q.size(), W * H);
      check_result({name, "_lines"}, lines_seen, H);
      if (got_q.size() == W * H)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
               ones += int'(exp_mask[y][x]);
               check_result($sformatf("%s_px_%0d_%0d", name, x, y), got_q[y*W+x], exp_mask[y][x]);
            end
      $display("frame %s mode %0d: %0d pixels, %0d expected ones", name, mode, got_q.size(), ones);
   endtask

   // Output monitor: delay-line check, pixel capture, per-line length check.
   always @(negedge sys_clk) begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {per_frame_vsync, per_frame_href, per_frame_clken};
      if (sys_rst) begin
         rst_age   = 0;
         line_px   = 0;
         href_prev = 1'b0;
      end else begin
         if (rst_age < 1000) rst_age++;
         if (rst_age > LAT)
            check_result("sync_delay", {post_frame_vsync, post_frame_href, post_frame_clken}, hist[LAT]);
         if (post_frame_vsync && post_frame_href && post_frame_clken) begin
            got_q.push_back(post_img_Bit);
            line_px++;
         end
         if (href_prev && !post_frame_href && post_frame_vsync) begin
            lines_seen++;
            if (check_lines) check_result("line_px", line_px, W);
            line_px = 0;
         end
         href_prev = post_frame_href;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) hist[i] = 3'b000;
      sys_rst         = 1'b1;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      pix_data_in_A   = 24'h0;
      pix_data_in_B   = 24'h0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check_result("reset_outputs",
         {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit}, 4'h0);
      step();
      sys_rst = 1'b0;

      fill(24'h808080, 24'h808080);
      run_frame("equal", 0);

      fill(24'h000000, 24'h000000);
      rect_b(8, 5, 6, 6, 24'hFFFFFF);
      run_frame("block", 1);

      fill(24'h000000, 24'h000000);
      rect_b(10, 7, 1, 1, 24'hFFFFFF);
      run_frame("dot", 0);

      fill(24'h000000, 24'h000000);
      rect_b(12, 0, 2, H, 24'hFFFFFF);
      run_frame("line2", 2);

      fill(24'h505050, 24'h646464);
      run_frame("diff20", 0);

      fill(24'h505050, 24'h656565);
      run_frame("diff21", 1);

      // mid-frame reset, then the block frame must come out exactly again
      fill(24'h000000, 24'h000000);
      rect_b(8, 5, 6, 6, 24'hFFFFFF);
      check_lines = 1'b0;
      got_q.delete();
      drive_frame(1, 6);
      check_lines = 1'b1;
      run_frame("after_rst", 1);

      for (int f = 0; f < 6; f++) begin
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
               img_a[y][x] = 24'($urandom);
               img_b[y][x] = img_a[y][x];
            end
         for (int r = 0; r < int'($urandom_range(1, 3)); r++)
            rect_b($urandom_range(0, W - 1), $urandom_range(0, H - 1),
                   $urandom_range(1, 9), $urandom_range(1, 7), 24'($urandom));
         for (int n = 0; n < 5; n++)
            img_b[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 24'($urandom);
         run_frame($sformatf("rand%0d", f), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
